spi_reg_peripheral: RTL



---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_reg_peripheral_sync_ff.sv | 25 ++
 rtl/spi_reg_peripheral.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register peripheral.
package spi_reg_pkg;

  localparam int unsigned XFER_BITS = 16;
  localparam int unsigned CNT_W     = $clog2(XFER_BITS + 2);
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_reg_peripheral_sync_ff.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 target decoding 16-bit frames into five PWM control registers.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XFER_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(XFER_BITS + 1);

  logic w_sclk_s;
  logic w_copi_s;
  logic w_ncs_s;
  logic r_sclk_d;
  logic r_ncs_d;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_commit;

  state_t                 r_state;
  logic [XFER_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_en_out_lo;
  logic [DATA_W-1:0]      r_en_out_hi;
  logic [DATA_W-1:0]      r_en_pwm_lo;
  logic [DATA_W-1:0]      r_en_pwm_hi;
  logic [DATA_W-1:0]      r_duty;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sclk),
    .o_q   (w_sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (copi),
    .o_q   (w_copi_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ncs),
    .o_q   (w_ncs_s)
  );

  // Delay the synchronised strobes by one cycle for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_ncs_d  <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ncs_d  <= w_ncs_s;
    end
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

  // A frame is accepted only if exactly XFER_BITS bits arrived, it is a write, and the address is in range.
  assign w_commit = (r_bit_cnt == CNT_FULL)
                  && r_shift[XFER_BITS-1]
                  && (r_shift[XFER_BITS-2 -: ADDR_W] <= MAX_ADDR);

  // Transaction FSM: shift on sclk rise, commit the decoded write on ncs rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ncs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            if (w_commit) begin
              case (r_shift[XFER_BITS-2 -: ADDR_W])
                ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[DATA_W-1:0];
                ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[DATA_W-1:0];
                ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[DATA_W-1:0];
                ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[DATA_W-1:0];
                ADDR_DUTY:      r_duty      <= r_shift[DATA_W-1:0];
                default: ;
              endcase
            end
            r_state <= IDLE;
          end else if (w_ncs_fall) begin
            // Missed rise (glitch): restart the frame as on IDLE entry.
            r_shift   <= '0;
            r_bit_cnt <= '0;
          end else if (w_sclk_rise && !w_ncs_s) begin
            r_shift <= {r_shift[XFER_BITS-2:0], w_copi_s};
            if (r_bit_cnt != CNT_OVF) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;

endmodule
